xmit_top: RTL and testbench
===========================

XMIT_TOP -- requirements
Module: xmit_top

Interface
REQ-001 Parameter DATA_DEPTH, default 256, bytes of data buffer per priority queue.
REQ-002 Parameter CTRL_DEPTH, default 4, frame descriptors per priority queue.
REQ-003 clk_sys  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 f_hi_priority  in  1  frame priority, sampled with f_rec_frame_valid (1 = high).
REQ-006 f_rec_frame_valid  in  1  one-cycle frame-start strobe qualifying f_ctrl_in.
REQ-007 f_ctrl_in  in  24  control block: [11:0] frame length in bytes; [23:12] reserved, ignored.
REQ-008 f_rec_data_valid  in  1  qualifies f_data_in; first byte coincides with f_rec_frame_valid.
REQ-009 f_data_in  in  8  frame byte.
REQ-010 phy_data_out  out  4  transmit nibble.
REQ-011 phy_tx_en  out  1  high while phy_data_out carries frame nibbles.
REQ-012 m_discard_en  out  1  one-cycle pulse per discarded frame.

Function
REQ-013 Two queues (high, low); each has one byte FIFO (DATA_DEPTH) and one descriptor FIFO (CTRL_DEPTH, entry = 12-bit length).
REQ-014 On f_rec_frame_valid with no frame open: accept if 1 <= length <= DATA_DEPTH, selected queue's free bytes (minus bytes reserved by an open frame) >= length, and descriptor FIFO not full; else discard.
REQ-015 Accept opens a frame: latch queue and length, clear byte counter; bytes with f_rec_data_valid=1 (including the strobe cycle) written in order.
REQ-016 Frame closes on the cycle its length-th byte is written; descriptor pushed that cycle; further data bytes ignored until next accept.
REQ-017 f_rec_data_valid with no frame open is ignored; bytes of a discarded frame are never written.
REQ-018 f_rec_frame_valid while a frame is open: the new frame is discarded; open frame continues unaffected.
REQ-019 Discard: m_discard_en=1 for exactly the cycle after the rejected strobe.
REQ-020 Transmitter FSM states IDLE, LOAD, SEND_LO, SEND_HI, GAP.
REQ-021 IDLE: if high descriptor FIFO non-empty pop it, else if low non-empty pop it; go LOAD. Strict priority, decided only in IDLE; no preemption mid-frame.
REQ-022 LOAD: read first byte of chosen queue; go SEND_LO.
REQ-023 SEND_LO: phy_data_out=byte[3:0], phy_tx_en=1; go SEND_HI. SEND_HI: phy_data_out=byte[7:4], phy_tx_en=1; if bytes remain fetch next byte and go SEND_LO, else go GAP.
REQ-024 Frame of N bytes produces exactly 2N consecutive cycles of phy_tx_en=1, low nibble first.
REQ-025 GAP: phy_tx_en=0 for 2 cycles, then IDLE.
REQ-026 Outside SEND states phy_data_out=4'h0, phy_tx_en=0; outputs registered.
REQ-027 Latency: first phy_tx_en=1 is 3 cycles after the edge writing the last byte when the transmitter is IDLE.
REQ-028 Simultaneous write and read on a byte FIFO are legal; occupancy accounting must use both.
REQ-029 FIFO pointers wrap modulo depth; full/empty from count, never overflow or underflow.

Reset
REQ-030 reset=0 asynchronously empties all FIFOs, closes any open frame, FSM to IDLE, all outputs 0.
REQ-031 Reset mid-frame drops in-flight frames without a discard pulse; normal operation starts first edge after release.

Structure
REQ-032 Shared package xmit_pkg: DATA_DEPTH/CTRL_DEPTH defaults, length width (12), FSM state encoding.
REQ-033 One sub-module xmit_fifo (parameterised width/depth synchronous FIFO with count), instantiated four times.

Verification
REQ-034 Single low-priority 64-byte frame, ctrl 24'h040040, bytes FF x4, 00 x56, FF x4 -> 128 cycles phy_tx_en=1, nibbles F x8, 0 x112, F x8; no discard.
REQ-035 64 back-to-back 64-byte frames every 74 cycles -> every transmitted frame 128 nibbles bit-exact; discards occur; m_discard_en pulses + frames sent = 64.
REQ-036 Low frame then high frame queued while a third frame transmits -> high frame sent next.
REQ-037 Ctrl length 0 and length 300 -> one m_discard_en pulse each, nothing transmitted.
REQ-038 Second strobe during open frame -> one discard pulse; first frame transmitted intact.
REQ-039 reset asserted mid-transmission -> phy_tx_en=0 immediately; no output until new frame.

Source files
------------

// File: rtl/xmit_pkg.sv
// Shared constants for the two-priority nibble transmitter: depth defaults,
// descriptor length width, transmitter state encoding and receive context.
package xmit_pkg;
  localparam int unsigned DATA_DEPTH_DEF = 256;
  localparam int unsigned CTRL_DEPTH_DEF = 4;
  localparam int unsigned LEN_W          = 12;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_SEND_LO = 3'd2;
  localparam logic [2:0] ST_SEND_HI = 3'd3;
  localparam logic [2:0] ST_GAP     = 3'd4;

  typedef logic [LEN_W-1:0] len_t;

  // Receive-side context of the frame currently being written.
  typedef struct packed {
    logic open;
    logic hi;
    len_t len;
    len_t cnt;
  } rx_ctx_t;
endpackage

// File: rtl/xmit_fifo.sv
// Synchronous FIFO with occupancy count; pointers wrap modulo DEPTH, and
// writes when full / reads when empty are dropped.
module xmit_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_ok, rd_ok;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    wr_ok    = wr_en && (32'(count_q) != DEPTH);
    rd_ok    = rd_en && (count_q != '0);
    wr_ptr_d = wr_ok ? bump(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_ok ? bump(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];
  assign count   = count_q;
endmodule

// File: rtl/xmit_top.sv
// Two-priority frame buffer: admits byte frames into high/low queues and
// serialises whole frames as nibbles, strict priority chosen between frames.
import xmit_pkg::*;

module xmit_top #(
  parameter int unsigned DATA_DEPTH = DATA_DEPTH_DEF,
  parameter int unsigned CTRL_DEPTH = CTRL_DEPTH_DEF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        f_hi_priority,
  input  logic        f_rec_frame_valid,
  input  logic [23:0] f_ctrl_in,
  input  logic        f_rec_data_valid,
  input  logic [7:0]  f_data_in,
  output logic [3:0]  phy_data_out,
  output logic        phy_tx_en,
  output logic        m_discard_en
);
  localparam int unsigned DCW = $clog2(DATA_DEPTH + 1);
  localparam int unsigned CCW = $clog2(CTRL_DEPTH + 1);

  logic [1:0]            dwr_en, drd_en, cwr_en, crd_en;
  logic [1:0][7:0]       drd_data;
  logic [1:0][LEN_W-1:0] crd_data;
  logic [1:0][DCW-1:0]   dcnt;
  logic [1:0][CCW-1:0]   ccnt;

  rx_ctx_t     rx_q, rx_d;
  len_t        new_len;
  logic [31:0] free;
  logic        accept, discard_d, discard_q;

  logic [2:0]  state_q, state_d;
  logic        sel_q, sel_d, gap_q, gap_d;
  len_t        rem_q, rem_d;
  logic [7:0]  byte_q, byte_d;
  logic        phy_en_d, phy_en_q;
  logic [3:0]  phy_data_d, phy_data_q;
  logic        unused_ctrl;

  assign unused_ctrl = ^f_ctrl_in[23:LEN_W];

  // Index 1 is the high-priority queue, index 0 the low one.
  for (genvar q = 0; q < 2; q++) begin : g_q
    xmit_fifo #(.W(8), .DEPTH(DATA_DEPTH)) u_data (
      .clk(clk_sys), .rst_n(reset), .wr_en(dwr_en[q]), .wr_data(f_data_in),
      .rd_en(drd_en[q]), .rd_data(drd_data[q]), .count(dcnt[q]));
    xmit_fifo #(.W(LEN_W), .DEPTH(CTRL_DEPTH)) u_ctrl (
      .clk(clk_sys), .rst_n(reset), .wr_en(cwr_en[q]), .wr_data(rx_d.len),
      .rd_en(crd_en[q]), .rd_data(crd_data[q]), .count(ccnt[q]));
  end

  // Admission only happens with no frame open, so no bytes are reserved by
  // an in-progress frame at decision time; the FIFO count is the whole story.
  always_comb begin
    rx_d      = rx_q;
    dwr_en    = '0;
    cwr_en    = '0;
    new_len   = f_ctrl_in[LEN_W-1:0];
    free      = DATA_DEPTH - 32'(dcnt[f_hi_priority]);
    accept    = f_rec_frame_valid && !rx_q.open && (new_len != '0) &&
                (32'(new_len) <= DATA_DEPTH) && (32'(new_len) <= free) &&
                (ccnt[f_hi_priority] != CCW'(CTRL_DEPTH));
    discard_d = f_rec_frame_valid && !accept;
    if (accept) begin
      rx_d.open = 1'b1;
      rx_d.hi   = f_hi_priority;
      rx_d.len  = new_len;
      rx_d.cnt  = '0;
    end
    if (rx_d.open && f_rec_data_valid) begin
      dwr_en[rx_d.hi] = 1'b1;
      rx_d.cnt        = rx_d.cnt + LEN_W'(1);
      if (rx_d.cnt == rx_d.len) begin
        cwr_en[rx_d.hi] = 1'b1;
        rx_d.open       = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rem_d   = rem_q;
    byte_d  = byte_q;
    gap_d   = gap_q;
    crd_en  = '0;
    drd_en  = '0;
    case (state_q)
      ST_IDLE: begin
        if (ccnt[1] != '0) begin
          crd_en[1] = 1'b1;
          sel_d     = 1'b1;
          rem_d     = crd_data[1];
          state_d   = ST_LOAD;
        end else if (ccnt[0] != '0) begin
          crd_en[0] = 1'b1;
          sel_d     = 1'b0;
          rem_d     = crd_data[0];
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        drd_en[sel_q] = 1'b1;
        byte_d        = drd_data[sel_q];
        rem_d         = rem_q - LEN_W'(1);
        state_d       = ST_SEND_LO;
      end
      ST_SEND_LO: state_d = ST_SEND_HI;
      ST_SEND_HI: begin
        if (rem_q != '0) begin
          drd_en[sel_q] = 1'b1;
          byte_d        = drd_data[sel_q];
          rem_d         = rem_q - LEN_W'(1);
          state_d       = ST_SEND_LO;
        end else begin
          gap_d   = 1'b0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q) state_d = ST_IDLE;
        else       gap_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the current state, one cycle behind it.
  always_comb begin
    phy_en_d   = (state_q == ST_SEND_LO) || (state_q == ST_SEND_HI);
    phy_data_d = (state_q == ST_SEND_LO) ? byte_q[3:0] :
                 (state_q == ST_SEND_HI) ? byte_q[7:4] : 4'h0;
  end

  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      rx_q       <= '0;
      discard_q  <= 1'b0;
      state_q    <= ST_IDLE;
      sel_q      <= 1'b0;
      gap_q      <= 1'b0;
      rem_q      <= '0;
      byte_q     <= '0;
      phy_en_q   <= 1'b0;
      phy_data_q <= '0;
    end else begin
      rx_q       <= rx_d;
      discard_q  <= discard_d;
      state_q    <= state_d;
      sel_q      <= sel_d;
      gap_q      <= gap_d;
      rem_q      <= rem_d;
      byte_q     <= byte_d;
      phy_en_q   <= phy_en_d;
      phy_data_q <= phy_data_d;
    end
  end

  assign phy_tx_en    = phy_en_q;
  assign phy_data_out = phy_data_q;
  assign m_discard_en = discard_q;
endmodule

// File: tb/tb_xmit_top.sv
// Directed bench for xmit_top: expected frames are queued when driven and
// matched nibble-by-nibble as the transmitter emits them.
module tb_xmit_top;
  logic        clk_sys = 1'b0;
  logic        reset;
  logic        f_hi_priority, f_rec_frame_valid, f_rec_data_valid;
  logic [23:0] f_ctrl_in;
  logic [7:0]  f_data_in;
  logic [3:0]  phy_data_out;
  logic        phy_tx_en, m_discard_en;

  xmit_top dut (
    .clk_sys(clk_sys), .reset(reset), .f_hi_priority(f_hi_priority),
    .f_rec_frame_valid(f_rec_frame_valid), .f_ctrl_in(f_ctrl_in),
    .f_rec_data_valid(f_rec_data_valid), .f_data_in(f_data_in),
    .phy_data_out(phy_data_out), .phy_tx_en(phy_tx_en), .m_discard_en(m_discard_en));

  always #5 clk_sys = ~clk_sys;

  int checks = 0, errors = 0;
  int cyc = 0, last_cyc = 0, rise_cyc = 0;
  int frames_sent = 0, discards = 0, tx_cycles = 0;
  int last_id = 0;
  bit id_mode = 1'b0;
  int exp_len[$];
  int exp_seed[$];
  logic [3:0] cur[$];

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gen_byte(input int seed, input int i);
    if (seed < 0) return (i < 4 || i >= 60) ? 8'hFF : 8'h00;
    if (i == 0) return 8'(seed);
    return 8'(seed * 13 + i * 29 + 5);
  endfunction

  task automatic finish_frame();
    int n, seed, bad;
    logic [7:0] b;
    bad = 0;
    if (id_mode) begin
      seed = int'({cur[1], cur[0]});
      n = 64;
      check("order_id", 32'(seed > last_id), 1);
      last_id = seed;
    end else if (exp_len.size() == 0) begin
      check("unexpected_frame_nibbles", cur.size(), 0);
      cur.delete();
      return;
    end else begin
      n = exp_len.pop_front();
      seed = exp_seed.pop_front();
    end
    check("frame_nibbles", cur.size(), 2 * n);
    for (int i = 0; i < n; i++) begin
      b = gen_byte(seed, i);
      if (2 * i + 1 >= cur.size()) bad++;
      else if (cur[2*i] !== b[3:0] || cur[2*i+1] !== b[7:4]) bad++;
    end
    check("frame_bad_bytes", bad, 0);
    frames_sent++;
    cur.delete();
  endtask

  always @(negedge clk_sys) begin
    if (!reset) cur.delete();
    else begin
      if (m_discard_en) discards++;
      if (phy_tx_en) begin
        if (cur.size() == 0) rise_cyc = cyc;
        cur.push_back(phy_data_out);
        tx_cycles++;
      end else if (cur.size() != 0) finish_frame();
    end
  end

  task automatic idle_inputs();
    f_rec_frame_valid = 1'b0;
    f_rec_data_valid  = 1'b0;
    f_hi_priority     = 1'b0;
    f_ctrl_in         = '0;
    f_data_in         = '0;
  endtask

  // dup_at >= 0 raises a second strobe (opposite priority, length 10) on that byte.
  task automatic send_frame(input bit hi, input logic [23:0] ctrl, input int n,
                            input int seed, input int dup_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      f_rec_frame_valid = (i == 0) || (i == dup_at);
      f_hi_priority     = (i == dup_at) ? ~hi : hi;
      f_ctrl_in         = (i == dup_at) ? 24'h00000A : ctrl;
      f_rec_data_valid  = 1'b1;
      f_data_in         = gen_byte(seed, i);
    end
    @(negedge clk_sys);
    idle_inputs();
    last_cyc = cyc;
  endtask

  task automatic push_exp(input int n, input int seed);
    exp_len.push_back(n);
    exp_seed.push_back(seed);
  endtask

  task automatic wait_drain(input int bound, input string tag);
    int n = 0;
    while ((exp_len.size() != 0 || phy_tx_en) && n < bound) begin
      @(negedge clk_sys);
      n++;
    end
    repeat (8) @(negedge clk_sys);
    check(tag, exp_len.size(), 0);
  endtask

  initial begin
    int d0, f0, t0, n;
    reset = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk_sys);
    check("rst_tx_en", phy_tx_en, 0);
    check("rst_data", phy_data_out, 0);
    check("rst_discard", m_discard_en, 0);
    #2 reset = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Single low-priority 64-byte frame, FF x4 / 00 x56 / FF x4.
    push_exp(64, -1);
    send_frame(1'b0, 24'h040040, 64, -1, -1);
    wait_drain(400, "t34_drain");
    check("t34_frames", frames_sent, 1);
    check("t34_tx_cycles", tx_cycles, 128);
    check("t34_no_discard", discards, 0);
    check("t34_latency", rise_cyc - last_cyc, 3);

    // Length 0 and length 300 are rejected with one pulse each.
    d0 = discards; f0 = frames_sent; t0 = tx_cycles;
    @(negedge clk_sys);
    f_rec_frame_valid = 1'b1; f_rec_data_valid = 1'b1; f_ctrl_in = 24'h0; f_data_in = 8'h55;
    @(negedge clk_sys);
    idle_inputs();
    check("t37_pulse_on", m_discard_en, 1);
    @(negedge clk_sys);
    check("t37_pulse_off", m_discard_en, 0);
    send_frame(1'b1, 24'h00012C, 8, 9, -1);
    repeat (50) @(negedge clk_sys);
    check("t37_discards", discards - d0, 2);
    check("t37_no_frames", frames_sent - f0, 0);
    check("t37_no_tx", tx_cycles - t0, 0);

    // Second strobe inside an open frame is dropped, first frame intact.
    d0 = discards; f0 = frames_sent;
    push_exp(20, 2);
    send_frame(1'b0, 24'd20, 20, 2, 5);
    wait_drain(400, "t38_drain");
    check("t38_discards", discards - d0, 1);
    check("t38_frames", frames_sent - f0, 1);

    // Low then high queued behind an in-flight frame: high goes next.
    f0 = frames_sent;
    push_exp(64, 3);
    push_exp(16, 5);
    push_exp(16, 4);
    send_frame(1'b0, 24'd64, 64, 3, -1);
    n = 0;
    while (!phy_tx_en && n < 50) begin @(negedge clk_sys); n++; end
    check("t36_started", phy_tx_en, 1);
    send_frame(1'b0, 24'd16, 16, 4, -1);
    send_frame(1'b1, 24'd16, 16, 5, -1);
    wait_drain(800, "t36_drain");
    check("t36_frames", frames_sent - f0, 3);

    // Overload: 64 frames every 74 cycles, ids 100..163 in byte 0.
    d0 = discards; f0 = frames_sent;
    id_mode = 1'b1;
    last_id = 99;
    for (int k = 0; k < 64; k++) begin
      send_frame(1'b0, 24'd64, 64, 100 + k, -1);
      repeat (9) @(negedge clk_sys);
    end
    n = 0;
    while (phy_tx_en && n < 1500) begin @(negedge clk_sys); n++; end
    repeat (900) @(negedge clk_sys);
    check("t35_quiet", phy_tx_en, 0);
    id_mode = 1'b0;
    check("t35_total", (discards - d0) + (frames_sent - f0), 64);
    check("t35_some_discard", 32'((discards - d0) > 0), 1);
    check("t35_some_sent", 32'((frames_sent - f0) >= 4), 1);

    // Reset in the middle of a transmission.
    push_exp(64, 7);
    send_frame(1'b0, 24'd64, 64, 7, -1);
    n = 0;
    while (!phy_tx_en && n < 50) begin @(negedge clk_sys); n++; end
    check("t39_started", phy_tx_en, 1);
    repeat (20) @(negedge clk_sys);
    #2 reset = 1'b0;
    #1;
    check("t39_tx_off", phy_tx_en, 0);
    check("t39_data_off", phy_data_out, 0);
    exp_len.delete();
    exp_seed.delete();
    repeat (2) @(negedge clk_sys);
    #2 reset = 1'b1;
    f0 = frames_sent; t0 = tx_cycles; d0 = discards;
    repeat (300) @(negedge clk_sys);
    check("t39_silent", tx_cycles - t0, 0);
    check("t39_no_discard", discards - d0, 0);
    push_exp(10, 8);
    send_frame(1'b1, 24'd10, 10, 8, -1);
    wait_drain(200, "t39_drain");
    check("t39_new_frame", frames_sent - f0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
